// File: rtl/irq_source_ctrl_if.sv
// Load/store bus and interrupt handshake between the core (master) and the
// interrupt source controller (slave).
interface irq_source_ctrl_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wr_en;
    logic        bus_rd_en;
    logic [31:0] bus_rdata;
    logic        csr_flush;
    logic        mret_MW;
    logic [31:0] cause;
    logic        irq_busy;

    modport master (
        output bus_addr, bus_wdata, bus_wr_en, bus_rd_en, csr_flush, mret_MW,
        input  bus_rdata, cause, irq_busy
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_wr_en, bus_rd_en, csr_flush, mret_MW,
        output bus_rdata, cause, irq_busy
    );
endinterface

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: memory-mapped 64-bit machine timer plus an
// external-interrupt capture path, presenting one cause at a time to the CSR unit.
module irq_source_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_irq,
    irq_source_ctrl_if.slave bus
);
    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;
    localparam logic [4:0] OFF_PEND        = 5'h14;

    logic [63:0]            mtime_q, mtime_d;
    logic [63:0]            mtimecmp_q, mtimecmp_d;
    logic                   ten_q, ten_d;
    logic                   een_q, een_d;
    logic                   ep_q, ep_d;
    logic [PS_W-1:0]        ps_cnt_q, ps_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ext_dly_q, ext_dly_d;
    logic [1:0]             state_q, state_d;
    logic [31:0]            cause_q, cause_d;
    logic                   src_ext_q, src_ext_d;
    logic                   busy_q, busy_d;

    logic        in_win_c;
    logic [4:0]  off_c;
    logic        wr_c;
    logic        tick_c;
    logic        tp_c;
    logic        ext_rise_c;
    logic        ep_ack_c;
    logic [31:0] rdata_c;

    // 32-byte window; low address bits take part so misaligned offsets read 0
    assign in_win_c   = (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
    assign off_c      = bus.bus_addr[4:0];
    assign wr_c       = bus.bus_wr_en && in_win_c;
    assign tick_c     = (ps_cnt_q == PS_LAST);
    assign tp_c       = ten_q && (mtime_q >= mtimecmp_q);
    assign ext_rise_c = sync_q[SYNC_STAGES-1] && !ext_dly_q;

    // Timer, control and pending-bit next state
    always_comb begin
        ps_cnt_d   = tick_c ? '0 : ps_cnt_q + PS_W'(1);
        mtime_d    = tick_c ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        ten_d      = ten_q;
        een_d      = een_q;
        ep_d       = ep_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], ext_irq};
        ext_dly_d  = sync_q[SYNC_STAGES-1];
        if (wr_c) begin
            case (off_c)
                OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], bus.bus_wdata};
                OFF_MTIME_HI:    mtime_d = {bus.bus_wdata, mtime_q[31:0]};
                OFF_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus.bus_wdata};
                OFF_MTIMECMP_HI: mtimecmp_d = {bus.bus_wdata, mtimecmp_q[31:0]};
                OFF_CTRL: begin
                    ten_d = bus.bus_wdata[0];
                    een_d = bus.bus_wdata[1];
                end
                OFF_PEND:        if (bus.bus_wdata[1]) ep_d = 1'b0;
                default: ;
            endcase
        end
        if (ep_ack_c) ep_d = 1'b0;
        // a new edge beats a same-cycle clear
        if (ext_rise_c && een_q) ep_d = 1'b1;
    end

    // Handshake FSM: IDLE -> REQ (cause held) -> SERVICE (wait for mret)
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        src_ext_d = src_ext_q;
        ep_ack_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cause_d = '0;
                if (ep_q) begin
                    state_d   = ST_REQ;
                    cause_d   = CAUSE_EXT;
                    src_ext_d = 1'b1;
                end else if (tp_c) begin
                    state_d   = ST_REQ;
                    cause_d   = CAUSE_TMR;
                    src_ext_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus.csr_flush) begin
                    state_d  = ST_SERVICE;
                    cause_d  = '0;
                    ep_ack_c = src_ext_q;
                end
            end
            ST_SERVICE: begin
                cause_d = '0;
                if (bus.mret_MW) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cause_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Load data; zero outside the window and on unmapped offsets
    always_comb begin
        rdata_c = '0;
        if (bus.bus_rd_en && in_win_c) begin
            case (off_c)
                OFF_MTIME_LO:    rdata_c = mtime_q[31:0];
                OFF_MTIME_HI:    rdata_c = mtime_q[63:32];
                OFF_MTIMECMP_LO: rdata_c = mtimecmp_q[31:0];
                OFF_MTIMECMP_HI: rdata_c = mtimecmp_q[63:32];
                OFF_CTRL:        rdata_c = {30'd0, een_q, ten_q};
                OFF_PEND:        rdata_c = {30'd0, ep_q, tp_c};
                default:         rdata_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ten_q      <= 1'b0;
            een_q      <= 1'b0;
            ep_q       <= 1'b0;
            ps_cnt_q   <= '0;
            sync_q     <= '0;
            ext_dly_q  <= 1'b0;
            state_q    <= ST_IDLE;
            cause_q    <= '0;
            src_ext_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ten_q      <= ten_d;
            een_q      <= een_d;
            ep_q       <= ep_d;
            ps_cnt_q   <= ps_cnt_d;
            sync_q     <= sync_d;
            ext_dly_q  <= ext_dly_d;
            state_q    <= state_d;
            cause_q    <= cause_d;
            src_ext_q  <= src_ext_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.bus_rdata = rdata_c;
    assign bus.cause     = cause_q;
    assign bus.irq_busy  = busy_q;
endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl: a PRESCALE=1 instance for the handshake
// and register behaviour, and a PRESCALE=4 instance for the timer divider.
module tb_irq_source_ctrl;
    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] A_MLO  = BASE + 32'h00;
    localparam logic [31:0] A_MHI  = BASE + 32'h04;
    localparam logic [31:0] A_CLO  = BASE + 32'h08;
    localparam logic [31:0] A_CHI  = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL = BASE + 32'h10;
    localparam logic [31:0] A_PEND = BASE + 32'h14;
    localparam logic [31:0] C_TMR  = 32'h8000_0007;
    localparam logic [31:0] C_EXT  = 32'h8000_000B;

    logic clk = 1'b0;
    logic rst;
    logic ext_a, ext_b;
    int   n_cmp = 0;
    int   n_err = 0;

    irq_source_ctrl_if ifa ();
    irq_source_ctrl_if ifb ();

    irq_source_ctrl #(.BASE_ADDR(BASE), .PRESCALE(1), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .ext_irq(ext_a), .bus(ifa));
    irq_source_ctrl #(.BASE_ADDR(BASE), .PRESCALE(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .ext_irq(ext_b), .bus(ifb));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input logic [31:0] addr, output logic [31:0] data);
        ifa.bus_addr  = addr;
        ifa.bus_rd_en = 1'b1;
        #1;
        data = ifa.bus_rdata;
        ifa.bus_rd_en = 1'b0;
    endtask

    task automatic rd_b(input logic [31:0] addr, output logic [31:0] data);
        ifb.bus_addr  = addr;
        ifb.bus_rd_en = 1'b1;
        #1;
        data = ifb.bus_rdata;
        ifb.bus_rd_en = 1'b0;
    endtask

    task automatic wr_a(input logic [31:0] addr, input logic [31:0] data);
        ifa.bus_addr  = addr;
        ifa.bus_wdata = data;
        ifa.bus_wr_en = 1'b1;
        step();
        ifa.bus_wr_en = 1'b0;
    endtask

    task automatic wr_b(input logic [31:0] addr, input logic [31:0] data);
        ifb.bus_addr  = addr;
        ifb.bus_wdata = data;
        ifb.bus_wr_en = 1'b1;
        step();
        ifb.bus_wr_en = 1'b0;
    endtask

    task automatic flush_a();
        ifa.csr_flush = 1'b1;
        step();
        ifa.csr_flush = 1'b0;
    endtask

    task automatic mret_a();
        ifa.mret_MW = 1'b1;
        step();
        ifa.mret_MW = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        found;

        rst = 1'b1;
        ext_a = 1'b0;
        ext_b = 1'b0;
        ifa.bus_addr = '0; ifa.bus_wdata = '0; ifa.bus_wr_en = 1'b0; ifa.bus_rd_en = 1'b0;
        ifa.csr_flush = 1'b0; ifa.mret_MW = 1'b0;
        ifb.bus_addr = '0; ifb.bus_wdata = '0; ifb.bus_wr_en = 1'b0; ifb.bus_rd_en = 1'b0;
        ifb.csr_flush = 1'b0; ifb.mret_MW = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_cause", ifa.cause, 0);
        chk("rst_busy", ifa.irq_busy, 0);
        chk("rst_cause_b", ifb.cause, 0);
        rd_a(A_MLO, d);  chk("rst_mtime_lo", d, 0);
        rd_a(A_CLO, d);  chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
        rd_a(A_CHI, d);  chk("rst_cmp_hi", d, 32'hFFFF_FFFF);
        rd_a(A_CTRL, d); chk("rst_ctrl", d, 0);
        rd_a(A_PEND, d); chk("rst_pend", d, 0);
        rd_a(32'h0000_1000, d); chk("rd_out_of_window", d, 0);
        rd_a(BASE + 32'h18, d); chk("rd_unmapped", d, 0);

        // timer request at mtime == 20
        wr_a(A_CHI, 0);
        wr_a(A_CLO, 20);
        wr_a(A_CTRL, 1);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            rd_a(A_MLO, d);
            if (d == 32'd20) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t1_reach20", found, 1);
        chk("t1_cause_same_cycle", ifa.cause, 0);
        step();
        chk("t1_cause_next", ifa.cause, C_TMR);
        chk("t1_busy", ifa.irq_busy, 1);
        repeat (3) step();
        chk("t1_cause_held", ifa.cause, C_TMR);
        flush_a();
        chk("t1_cause_after_flush", ifa.cause, 0);
        chk("t1_busy_service", ifa.irq_busy, 1);
        repeat (2) step();
        chk("t1_busy_wait_mret", ifa.irq_busy, 1);
        chk("t1_cause_service", ifa.cause, 0);
        mret_a();
        chk("t1_busy_idle", ifa.irq_busy, 0);
        chk("t1_cause_idle", ifa.cause, 0);
        step();
        chk("t1_reissue", ifa.cause, C_TMR);
        wr_a(A_CTRL, 0);
        chk("t1_ten_clear_keeps_req", ifa.cause, C_TMR);
        rd_a(A_PEND, d); chk("t1_pend_ten_off", d, 0);
        flush_a();
        mret_a();
        step();
        chk("t1_quiet_cause", ifa.cause, 0);
        chk("t1_quiet_busy", ifa.irq_busy, 0);

        // external and timer pending together: external first
        wr_a(A_CLO, 0);
        wr_a(A_CTRL, 2);
        ext_a = 1'b1;
        step();
        step();
        wr_a(A_CTRL, 3);
        chk("t2_cause_idle", ifa.cause, 0);
        rd_a(A_PEND, d); chk("t2_pend_both", d, 3);
        step();
        chk("t2_ext_first", ifa.cause, C_EXT);
        chk("t2_busy", ifa.irq_busy, 1);
        flush_a();
        chk("t2_cause_after_flush", ifa.cause, 0);
        rd_a(A_PEND, d); chk("t2_ep_acked", d, 1);
        mret_a();
        chk("t2_idle_gap", ifa.cause, 0);
        step();
        chk("t2_timer_second", ifa.cause, C_TMR);
        wr_a(A_CTRL, 0);
        flush_a();
        mret_a();
        ext_a = 1'b0;
        repeat (4) step();
        chk("t2_quiet", ifa.irq_busy, 0);

        // external pulse with EEN=0 is ignored
        ext_a = 1'b1;
        repeat (3) step();
        ext_a = 1'b0;
        repeat (4) step();
        rd_a(A_PEND, d); chk("t3_een_off_pend", d, 0);
        chk("t3_een_off_cause", ifa.cause, 0);
        chk("t3_een_off_busy", ifa.irq_busy, 0);

        // EP set while busy, cleared by W1C, never requested
        wr_a(A_CTRL, 1);
        step();
        chk("t3_tmr_req", ifa.cause, C_TMR);
        flush_a();
        wr_a(A_CTRL, 2);
        ext_a = 1'b1;
        repeat (3) step();
        rd_a(A_PEND, d); chk("t3_ep_set", d, 2);
        chk("t3_busy_service", ifa.irq_busy, 1);
        wr_a(A_PEND, 2);
        rd_a(A_PEND, d); chk("t3_ep_w1c", d, 0);
        ext_a = 1'b0;
        mret_a();
        repeat (2) step();
        chk("t3_no_req_cause", ifa.cause, 0);
        chk("t3_no_req_busy", ifa.irq_busy, 0);

        // mtime 64-bit wrap drops TP
        wr_a(A_CTRL, 0);
        wr_a(A_CHI, 32'hFFFF_FFFF);
        wr_a(A_CLO, 32'hFFFF_FFF0);
        wr_a(A_CTRL, 1);
        wr_a(A_MLO, 32'hFFFF_FFFF);
        wr_a(A_MHI, 32'hFFFF_FFFF);
        rd_a(A_MLO, d);  chk("t4_all_ones_lo", d, 32'hFFFF_FFFF);
        rd_a(A_MHI, d);  chk("t4_all_ones_hi", d, 32'hFFFF_FFFF);
        rd_a(A_PEND, d); chk("t4_tp_at_max", d, 1);
        chk("t4_cause_pre", ifa.cause, 0);
        step();
        rd_a(A_MLO, d);  chk("t4_wrap_lo", d, 0);
        rd_a(A_MHI, d);  chk("t4_wrap_hi", d, 0);
        rd_a(A_PEND, d); chk("t4_tp_dropped", d, 0);
        chk("t4_req_latched", ifa.cause, C_TMR);
        flush_a();
        mret_a();
        step();
        chk("t4_no_reissue", ifa.cause, 0);
        chk("t4_idle", ifa.irq_busy, 0);

        // reset mid-handshake
        wr_a(A_CLO, 0);
        wr_a(A_CHI, 0);
        wr_a(A_CTRL, 1);
        step();
        chk("t5_req", ifa.cause, C_TMR);
        rst = 1'b1;
        step();
        chk("t5_rst_cause", ifa.cause, 0);
        chk("t5_rst_busy", ifa.irq_busy, 0);
        rd_a(A_CHI, d);  chk("t5_rst_cmp_hi", d, 32'hFFFF_FFFF);
        rd_a(A_CTRL, d); chk("t5_rst_ctrl", d, 0);
        rst = 1'b0;

        // PRESCALE=4: one tick every 4 clocks, write on tick loads without +1
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rd_b(A_MLO, d);
            if (d == 32'd1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t6_first_tick", found, 1);
        repeat (3) step();
        rd_b(A_MLO, d); chk("t6_hold3", d, 1);
        step();
        rd_b(A_MLO, d); chk("t6_tick4", d, 2);
        repeat (3) step();
        wr_b(A_MLO, 100);
        rd_b(A_MLO, d); chk("t6_wr_on_tick", d, 100);
        repeat (3) step();
        rd_b(A_MLO, d); chk("t6_hold_after_wr", d, 100);
        step();
        rd_b(A_MLO, d); chk("t6_next_tick", d, 101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
